// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM/WB back end: widths, handshake state encoding,
// and the per-stage control record.
package pipeline_pkg;

  localparam int DEFAULT_XLEN   = 32;
  localparam int DEFAULT_REG_AW = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } memState_t;

  typedef struct packed {
    logic                      valid;
    logic                      regwrite;
    logic                      memtoreg;
    logic                      memread;
    logic                      memwrite;
    logic [DEFAULT_REG_AW-1:0] rd;
  } stageCtrl_t;

  localparam stageCtrl_t BUBBLE = '0;

  function automatic logic isMemOp(stageCtrl_t c);
    return c.valid & (c.memread | c.memwrite);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory request/acknowledge handshake. Raises stall while a request is
// outstanding and keeps a saturating count of stalled cycles.
module mem_access_fsm
  import pipeline_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memOpValid,
  input  logic        memAck,
  output logic        memReq,
  output logic        stall,
  output logic [15:0] stallCycles
);

  memState_t stateReg;
  memState_t stateNext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stateReg <= RUN;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN:     if (memOpValid && !memAck) stateNext = WAIT;
      WAIT:    if (memAck) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  // The MEM stage is frozen in WAIT, so the request stays asserted until ack.
  always_comb begin
    memReq = 1'b0;
    case (stateReg)
      RUN:     memReq = memOpValid;
      WAIT:    memReq = 1'b1;
      default: memReq = 1'b0;
    endcase
    stall = memReq & ~memAck;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            stallCycles <= '0;
    else if (stall && stallCycles != '1)  stallCycles <= stallCycles + 16'd1;
  end

endmodule

// File: rtl/mem_wb_pipeline.sv
// EX/MEM and MEM/WB stage registers with forwarding outputs; the memory
// handshake lives in mem_access_fsm and freezes both stages while waiting.
module mem_wb_pipeline
  import pipeline_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memtoreg_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_alu_result_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              stall_o,
  output logic              MemRegWrite_o,
  output logic [REG_AW-1:0] MemRd_o,
  output logic [XLEN-1:0]   mem_fwd_data_o,
  output logic              WBRegWrite_o,
  output logic [REG_AW-1:0] WBRd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [15:0]       stall_cycles_o
);

  logic              adv;
  logic              exTake;
  stageCtrl_t        exCtrl;
  stageCtrl_t        memCtrlReg;
  logic [XLEN-1:0]   memAluReg;
  logic [XLEN-1:0]   memStoreReg;
  logic              wbValidReg;
  logic              wbRegwriteReg;
  logic [REG_AW-1:0] wbRdReg;
  logic [XLEN-1:0]   wbDataReg;

  assign adv    = ~stall_o;
  assign exTake = ex_valid_i & ~flush_i;

  always_comb begin
    exCtrl = BUBBLE;
    if (exTake) begin
      exCtrl.valid    = 1'b1;
      exCtrl.regwrite = ex_regwrite_i;
      exCtrl.memtoreg = ex_memtoreg_i;
      exCtrl.memread  = ex_memread_i;
      exCtrl.memwrite = ex_memwrite_i;
      exCtrl.rd       = ex_rd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memCtrlReg  <= BUBBLE;
      memAluReg   <= '0;
      memStoreReg <= '0;
    end else if (adv) begin
      memCtrlReg  <= exCtrl;
      memAluReg   <= exTake ? ex_alu_result_i : '0;
      memStoreReg <= exTake ? ex_store_data_i : '0;
    end
  end

  // On an advancing cycle any load in MEM has been acked, so rdata is valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbValidReg    <= 1'b0;
      wbRegwriteReg <= 1'b0;
      wbRdReg       <= '0;
      wbDataReg     <= '0;
    end else if (adv) begin
      wbValidReg    <= memCtrlReg.valid;
      wbRegwriteReg <= memCtrlReg.regwrite;
      wbRdReg       <= memCtrlReg.rd;
      wbDataReg     <= memCtrlReg.memtoreg ? mem_rdata_i : memAluReg;
    end
  end

  mem_access_fsm uAccess (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .memOpValid  (isMemOp(memCtrlReg)),
    .memAck      (mem_ack_i),
    .memReq      (mem_req_o),
    .stall       (stall_o),
    .stallCycles (stall_cycles_o)
  );

  assign mem_we_o       = memCtrlReg.memwrite & mem_req_o;
  assign mem_addr_o     = memAluReg;
  assign mem_wdata_o    = memStoreReg;
  assign MemRegWrite_o  = memCtrlReg.valid & memCtrlReg.regwrite & (memCtrlReg.rd != '0);
  assign MemRd_o        = memCtrlReg.rd;
  assign mem_fwd_data_o = memAluReg;
  assign WBRegWrite_o   = wbValidReg & wbRegwriteReg & (wbRdReg != '0);
  assign WBRd_o         = wbRdReg;
  assign wb_data_o      = wbDataReg;

endmodule

// File: doc/mem_wb_pipeline.md
# mem_wb_pipeline

Back-end pipeline block covering the EX/MEM and MEM/WB registers of the 5-stage RISC-V core. It drives the destination-register and write-enable signals that the forwarding logic consumes: MEM-stage `MemRegWrite_o`/`MemRd_o` and WB-stage `WBRegWrite_o`/`WBRd_o`, together with the matching forwardable data. It also runs the data-memory request/acknowledge handshake and raises a pipeline-wide stall while an access is outstanding.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register-index width

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `ex_valid_i`  in  1  EX stage holds a real instruction
- `ex_regwrite_i`  in  1  instruction writes the register file
- `ex_memtoreg_i`  in  1  writeback data comes from memory
- `ex_memread_i`  in  1  load
- `ex_memwrite_i`  in  1  store
- `ex_rd_i`  in  REG_AW  destination register
- `ex_alu_result_i`  in  XLEN  ALU result / memory address
- `ex_store_data_i`  in  XLEN  store data
- `flush_i`  in  1  insert a bubble into MEM instead of the EX instruction
- `mem_req_o`  out  1  data-memory request
- `mem_we_o`  out  1  request is a write
- `mem_addr_o`  out  XLEN  address
- `mem_wdata_o`  out  XLEN  write data
- `mem_ack_i`  in  1  memory completes the request this cycle
- `mem_rdata_i`  in  XLEN  load data, valid when `mem_ack_i`=1
- `stall_o`  out  1  freeze IF/ID/EX and this block
- `MemRegWrite_o`  out  1  MEM-stage register write enable
- `MemRd_o`  out  REG_AW  MEM-stage destination
- `mem_fwd_data_o`  out  XLEN  MEM-stage ALU result
- `WBRegWrite_o`  out  1  WB-stage register write enable
- `WBRd_o`  out  REG_AW  WB-stage destination
- `wb_data_o`  out  XLEN  WB-stage write data
- `stall_cycles_o`  out  16  saturating count of stall cycles

## Operation
- Advance condition: `adv = !stall_o`. Both stage registers load only when `adv` is high. While `adv` is low they hold their contents.
- EX/MEM load: if `flush_i` is high or `ex_valid_i` is low, load a bubble (every control bit 0, rd 0, data 0). Otherwise capture the EX inputs. `flush_i` has effect only on an advancing cycle.
- `MemRegWrite_o` = mem_valid & mem_regwrite & (mem_rd != 0). `WBRegWrite_o` is formed the same way from the WB stage. Register x0 is never reported as written.
- `mem_addr_o` = MEM ALU result. `mem_wdata_o` = MEM store data. `mem_we_o` = mem_memwrite & `mem_req_o`.
- MEM/WB load: capture valid, regwrite and rd. `wb_data` = mem_memtoreg ? `mem_rdata_i` : ALU result.
- Handshake FSM, states RUN and WAIT:
  - RUN: `mem_req_o` = mem_valid & (memread | memwrite).
    - If `mem_req_o` & `mem_ack_i`: stay in RUN; the pipeline advances.
    - If `mem_req_o` & !`mem_ack_i`: go to WAIT.
  - WAIT: `mem_req_o` = 1. Return to RUN on `mem_ack_i`.
  - `stall_o` = `mem_req_o` & !`mem_ack_i`. It is combinational from state and `mem_ack_i`.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` stay stable from the first request cycle through the ack cycle.
- If an instruction sets both memread and memwrite, memwrite wins.
- `stall_cycles_o` increments each cycle `stall_o`=1 and saturates at 0xFFFF.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to RUN; both stages become bubbles.
  - All outputs are 0: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `stall_o`, `MemRegWrite_o`, `MemRd_o`, `mem_fwd_data_o`, `WBRegWrite_o`, `WBRd_o`, `wb_data_o`, `stall_cycles_o`.
  - Asserting reset mid-access drops `mem_req_o` in the same cycle, and the pending access is abandoned.
- Latency with zero-wait memory: EX inputs reach the MEM outputs 1 cycle later and the WB outputs 2 cycles later.
- A request acked in its first cycle causes no stall.
- With N wait cycles, `stall_o` is high for N cycles and the WB outputs appear N+2 cycles after EX.
- During a stall the WB stage holds its values, so the same register write repeats. This is idempotent, and WB forwarding stays valid for the frozen EX instruction.
- Back-to-back memory ops: the second op's request begins in the cycle after the first op's ack, with no idle cycle between them.
- `mem_ack_i` is ignored whenever `mem_req_o`=0.

## Structure
- Shared package `pipeline_pkg` holds:
  - `XLEN` and `REG_AW` defaults
  - the FSM state encoding (RUN=0, WAIT=1)
  - a packed stage-control typedef (valid, regwrite, memtoreg, memread, memwrite, rd)
  - a bubble constant
- One sub-module: `mem_access_fsm`. It takes the MEM-stage op and `mem_ack_i`, and produces `mem_req_o`, `stall_o` and the stall counter.
- The stage registers stay in the top level.

## Test plan
- Add, rd=5, ALU result 0x10, no memory op:
  - Cycle +1: `MemRegWrite_o`=1, `MemRd_o`=5, `mem_fwd_data_o`=0x10.
  - Cycle +2: `WBRd_o`=5, `wb_data_o`=0x10.
  - `stall_o` stays 0 throughout.
- Load, rd=7, address 0x40, ack after 3 wait cycles, rdata 0xDEADBEEF:
  - `stall_o` is high for exactly 3 cycles; address and request are stable.
  - `wb_data_o`=0xDEADBEEF with `WBRd_o`=7.
  - `stall_cycles_o`=3.
- Instruction with rd=0 and regwrite=1: `MemRegWrite_o` and `WBRegWrite_o` stay 0.
- `flush_i`=1 together with a valid store: no `mem_req_o` is issued, and the next cycle's MEM outputs are all 0.
- Store to 0x80 with data 0x1234:
  - `mem_we_o`=1 with that address and data until ack.
  - `WBRegWrite_o`=0.
- Reset asserted during WAIT: `mem_req_o` and `stall_o` drop to 0 immediately. After release, an add passes with 2-cycle latency.
